fb_sram_arbiter: RTL

- Single owner of the off-chip frame-buffer SRAM. It holds 640x480 = 307200 words.
- Shares the SRAM between three requesters, one access per clock:
  - VGA scan-out reads (highest priority)
  - a stallable full-frame clear sweep
  - single-pixel draw writes (lowest priority)
- Sits between the VGA controller / draw engine and the SRAM pins. Replaces direct SRAM hookup of the clear logic.

---
 rtl/fb_sram_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/fb_sram_arbiter.sv
// Frame-buffer SRAM arbiter: one access per clock, shared between VGA reads,
// a stallable full-frame clear sweep and single-pixel draw writes.
module fb_sram_arbiter #(
    parameter int                ADDR_W     = 20,
    parameter int                DATA_W     = 16,
    parameter int                FB_WORDS   = 307200,
    parameter logic [DATA_W-1:0] CLEAR_DATA = '0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              drw_req,
    input  logic [ADDR_W-1:0] drw_addr,
    input  logic [DATA_W-1:0] drw_data,
    output logic              drw_ack,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_in,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              fsm_state
);

    // Handshake: a requester raises req with addr/data stable and holds them
    // until ack; ack is combinational and means the access was taken this cycle.

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WORDS - 1);
    localparam logic [ADDR_W:0]   FB_LIMIT  = (ADDR_W + 1)'(FB_WORDS);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic              clr_start_q;
    logic              clr_grant;
    logic              clr_last;
    logic              rd_in_range;
    logic              drw_in_range;
    logic              rd_p1;
    logic              rd_p1_ok;

    assign clr_busy  = (state == CLEAR);
    assign fsm_state = state;

    always_comb begin
        rd_ack       = rd_req;
        clr_grant    = !rd_req && (state == CLEAR);
        drw_ack      = !rd_req && (state != CLEAR) && drw_req;
        clr_last     = clr_grant && (cnt == LAST_ADDR);
        rd_in_range  = ({1'b0, rd_addr} < FB_LIMIT);
        drw_in_range = ({1'b0, drw_addr} < FB_LIMIT);
        state_nxt    = state;
        cnt_nxt      = cnt;
        case (state)
            IDLE: begin
                if (clr_start && !clr_start_q) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                // A pre-empted cycle leaves the counter alone, so no address is skipped.
                if (clr_grant) begin
                    if (clr_last) state_nxt = IDLE;
                    else          cnt_nxt   = cnt + ADDR_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            cnt         <= '0;
            clr_start_q <= 1'b0;
            clr_done    <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            clr_start_q <= clr_start;
            clr_done    <= clr_last;
        end
    end

    // SRAM pins are registered; the granted access occupies the following cycle.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_ce_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_we_n   <= 1'b1;
        end else if (rd_ack && rd_in_range) begin
            sram_addr   <= rd_addr;
            sram_dq_oe  <= 1'b0;
            sram_ce_n   <= 1'b0;
            sram_oe_n   <= 1'b0;
            sram_we_n   <= 1'b1;
        end else if (clr_grant) begin
            sram_addr   <= cnt;
            sram_dq_out <= CLEAR_DATA;
            sram_dq_oe  <= 1'b1;
            sram_ce_n   <= 1'b0;
            sram_oe_n   <= 1'b1;
            sram_we_n   <= 1'b0;
        end else if (drw_ack && drw_in_range) begin
            sram_addr   <= drw_addr;
            sram_dq_out <= drw_data;
            sram_dq_oe  <= 1'b1;
            sram_ce_n   <= 1'b0;
            sram_oe_n   <= 1'b1;
            sram_we_n   <= 1'b0;
        end else begin
            // Out-of-range reads land here too: acked, but the bus stays quiet.
            sram_dq_oe  <= 1'b0;
            sram_ce_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_we_n   <= 1'b1;
        end
    end

    // Read return pipeline: access in N+1, data presented in N+2.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rd_p1    <= 1'b0;
            rd_p1_ok <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_p1    <= rd_ack;
            rd_p1_ok <= rd_ack && rd_in_range;
            rd_valid <= rd_p1;
            if (rd_p1) rd_data <= rd_p1_ok ? sram_dq_in : '0;
        end
    end

endmodule
